// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types, constants and helpers for the UART TX engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4,
        TX_DONE   = 3'd5,
        TX_REARM  = 3'd6
    } tx_state_t;

    localparam int unsigned c_data_bits      = 8;
    localparam int unsigned c_frame_bits     = 10;
    localparam int unsigned c_frame_bits_par = 11;

    // Integer division truncates, matching the nominal bit period rounding.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
// ============================================================================
//  Module      : uart_baud_counter
//  Description : Bit-period timer; strobes bit_end on the last cycle of a bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic CLK100MHZ,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_end
);

    localparam int unsigned           c_cnt_w = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0]    c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            if (r_cnt == c_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_bit_end = i_enable && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_tx_engine.sv
// ============================================================================
//  Module      : uart_tx_engine
//  Description : 8N1 (optional parity) UART serializer with isTX/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       isTX,
    input  logic [7:0] data,
    output logic       UART_RXD_OUT,
    output logic       done,
    output logic       busy
);

    localparam int unsigned c_clks_per_bit = clks_per_bit(CLK_FREQ, BAUD);

    generate
        if (c_clks_per_bit < 2) begin : g_cpb_check
            $error("uart_tx_engine: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    tx_state_t  r_state,  w_state_nxt;
    logic [7:0] r_shift,  w_shift_nxt;
    logic [2:0] r_bit_idx, w_bit_idx_nxt;
    logic       r_parity, w_parity_nxt;
    logic       r_line,   w_line_nxt;
    logic       r_done,   w_done_nxt;
    logic       r_busy,   w_busy_nxt;
    logic       w_clear;
    logic       w_baud_en;
    logic       w_bit_end;

    assign w_baud_en = (r_state == TX_START) || (r_state == TX_DATA) ||
                       (r_state == TX_PARITY) || (r_state == TX_STOP);

    uart_baud_counter #(
        .CLKS_PER_BIT (c_clks_per_bit)
    ) u_baud (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_enable  (w_baud_en),
        .o_bit_end (w_bit_end)
    );

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_state   <= TX_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
            r_line    <= 1'b1;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_parity  <= w_parity_nxt;
            r_line    <= w_line_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Line value is registered one cycle ahead: each transition loads the next bit.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_parity_nxt  = r_parity;
        w_line_nxt    = r_line;
        w_done_nxt    = 1'b0;
        w_busy_nxt    = r_busy;
        w_clear       = 1'b0;

        case (r_state)
            TX_IDLE: begin
                w_line_nxt = 1'b1;
                if (isTX) begin
                    w_shift_nxt   = data;
                    w_parity_nxt  = (^data) ^ PARITY_ODD;
                    w_bit_idx_nxt = '0;
                    w_line_nxt    = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_clear       = 1'b1;
                    w_state_nxt   = TX_START;
                end
            end
            TX_START: begin
                if (w_bit_end) begin
                    w_line_nxt  = r_shift[0];
                    w_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'(c_data_bits - 1)) begin
                        w_bit_idx_nxt = '0;
                        if (PARITY_EN) begin
                            w_line_nxt  = r_parity;
                            w_state_nxt = TX_PARITY;
                        end else begin
                            w_line_nxt  = 1'b1;
                            w_state_nxt = TX_STOP;
                        end
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = r_shift >> 1;
                        w_line_nxt    = r_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (w_bit_end) begin
                    w_line_nxt  = 1'b1;
                    w_state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (w_bit_end) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = TX_DONE;
                end
            end
            TX_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = TX_REARM;
            end
            TX_REARM: begin
                // Hold off until upstream releases the request it just had serviced.
                if (!isTX) begin
                    w_state_nxt = TX_IDLE;
                end
            end
            default: begin
                w_line_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = TX_IDLE;
            end
        endcase
    end

    assign UART_RXD_OUT = r_line;
    assign done         = r_done;
    assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
// ============================================================================
//  Module      : tb_uart_tx_engine
//  Description : Self-checking bench for uart_tx_engine (868 and 4 clks/bit).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_engine;

    logic clk;
    logic reset_s, reset_f;

    logic       istx_s, line_s, done_s, busy_s;
    logic [7:0] data_s;
    logic       istx_f, line_f, done_f, busy_f;
    logic [7:0] data_f;
    logic       istx_p, line_pe, done_pe, busy_pe, line_po, done_po, busy_po;
    logic [7:0] data_p;

    int total = 0;
    int bad   = 0;
    int decoded = 0;
    logic [7:0] sb[$];

    typedef struct packed {
        logic [7:0] data;
        logic       even_bit;
        logic       odd_bit;
    } par_vec_t;

    uart_tx_engine #(.CLK_FREQ(100_000_000), .BAUD(115200)) u_slow (
        .CLK100MHZ(clk), .reset(reset_s), .isTX(istx_s), .data(data_s),
        .UART_RXD_OUT(line_s), .done(done_s), .busy(busy_s));

    uart_tx_engine #(.CLK_FREQ(400), .BAUD(100)) u_fast (
        .CLK100MHZ(clk), .reset(reset_f), .isTX(istx_f), .data(data_f),
        .UART_RXD_OUT(line_f), .done(done_f), .busy(busy_f));

    uart_tx_engine #(.CLK_FREQ(400), .BAUD(100), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_par_even (
        .CLK100MHZ(clk), .reset(reset_f), .isTX(istx_p), .data(data_p),
        .UART_RXD_OUT(line_pe), .done(done_pe), .busy(busy_pe));

    uart_tx_engine #(.CLK_FREQ(400), .BAUD(100), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_par_odd (
        .CLK100MHZ(clk), .reset(reset_f), .isTX(istx_p), .data(data_p),
        .UART_RXD_OUT(line_po), .done(done_po), .busy(busy_po));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Host receiver for the 4 clks/bit build: samples mid-bit, checks against scoreboard.
    initial begin : host_mon
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (line_f === 1'b0) begin
                repeat (2) @(negedge clk);
                chk("rx_start_mid", {31'd0, line_f}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = line_f;
                end
                repeat (4) @(negedge clk);
                chk("rx_stop_bit", {31'd0, line_f}, 32'd1);
                decoded++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: actual=%0h required=none", b);
                end else begin
                    e = sb.pop_front();
                    chk("rx_byte", {24'd0, b}, {24'd0, e});
                end
            end
        end
    end

    task automatic wait_done_f(input string nm);
        int n;
        n = 0;
        while (done_f !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, (n < 200)}, 32'd1);
    endtask

    // Sequencer-style request: drop isTX on done, re-raise two cycles later.
    task automatic send_f(input logic [7:0] b);
        data_f = b;
        istx_f = 1'b1;
        sb.push_back(b);
        @(negedge clk);
        chk("start_latency_line", {31'd0, line_f}, 32'd0);
        chk("start_latency_busy", {31'd0, busy_f}, 32'd1);
        wait_done_f("done_timeout_f");
        istx_f = 1'b0;
        @(negedge clk);
        chk("rearm_line_idle", {31'd0, line_f}, 32'd1);
        @(negedge clk);
    endtask

    task automatic slow_frame(input logic [7:0] b);
        logic [9:0] bits;
        logic [9:0] exp;
        int done_at, done_cnt, busy_cnt;
        exp = {1'b1, b, 1'b0};
        bits = '0;
        done_at = -1;
        done_cnt = 0;
        busy_cnt = 0;
        data_s = b;
        istx_s = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 9000; cyc++) begin
            if (busy_s) busy_cnt++;
            if (done_s) begin
                done_cnt++;
                done_at = cyc;
                istx_s = 1'b0;
            end
            if (cyc < 8680 && (cyc % 868) == 434) bits[cyc / 868] = line_s;
            @(negedge clk);
        end
        istx_s = 1'b0;
        chk("slow_frame_bits", {22'd0, bits}, {22'd0, exp});
        chk("slow_done_cycle", done_at, 32'd8680);
        chk("slow_done_pulses", done_cnt, 32'd1);
        chk("slow_busy_cycles", busy_cnt, 32'd8681);
    endtask

    initial begin : main
        par_vec_t   vecs[6];
        logic [10:0] fr_e, fr_o;
        int at_e, at_o, viol, done_cnt;

        vecs[0] = '{data: 8'hA1, even_bit: 1'b1, odd_bit: 1'b0};
        vecs[1] = '{data: 8'h00, even_bit: 1'b0, odd_bit: 1'b1};
        vecs[2] = '{data: 8'hFF, even_bit: 1'b0, odd_bit: 1'b1};
        vecs[3] = '{data: 8'h3C, even_bit: 1'b0, odd_bit: 1'b1};
        vecs[4] = '{data: 8'h80, even_bit: 1'b1, odd_bit: 1'b0};
        vecs[5] = '{data: 8'h7F, even_bit: 1'b1, odd_bit: 1'b0};

        istx_s = 1'b0; data_s = 8'h00;
        istx_f = 1'b0; data_f = 8'h00;
        istx_p = 1'b0; data_p = 8'h00;
        reset_s = 1'b1;
        reset_f = 1'b1;
        #1;
        chk("reset_line_s", {31'd0, line_s}, 32'd1);
        chk("reset_done_s", {31'd0, done_s}, 32'd0);
        chk("reset_busy_s", {31'd0, busy_s}, 32'd0);
        chk("reset_line_f", {31'd0, line_f}, 32'd1);
        chk("reset_busy_f", {31'd0, busy_f}, 32'd0);
        repeat (3) @(negedge clk);
        reset_s = 1'b0;
        reset_f = 1'b0;
        repeat (2) @(negedge clk);

        // Full-rate frame of 8'hA1.
        slow_frame(8'hA1);

        // Parity builds, table-driven.
        for (int v = 0; v < 6; v++) begin
            fr_e = '0; fr_o = '0; at_e = -1; at_o = -1;
            data_p = vecs[v].data;
            istx_p = 1'b1;
            @(negedge clk);
            for (int cyc = 0; cyc < 60; cyc++) begin
                if (done_pe) begin at_e = cyc; istx_p = 1'b0; end
                if (done_po) at_o = cyc;
                if (cyc < 44 && (cyc % 4) == 2) begin
                    fr_e[cyc / 4] = line_pe;
                    fr_o[cyc / 4] = line_po;
                end
                @(negedge clk);
            end
            istx_p = 1'b0;
            chk("par_even_frame", {21'd0, fr_e}, {21'd0, 1'b1, vecs[v].even_bit, vecs[v].data, 1'b0});
            chk("par_odd_frame",  {21'd0, fr_o}, {21'd0, 1'b1, vecs[v].odd_bit,  vecs[v].data, 1'b0});
            chk("par_even_len", at_e, 32'd44);
            chk("par_odd_len",  at_o, 32'd44);
        end

        // Sequencer pattern, back to back.
        send_f(8'hA1);
        send_f(8'hB2);
        send_f(8'hC3);
        send_f(8'hD4);

        // isTX held past done: no second frame, line idle in REARM.
        data_f = 8'h5A;
        istx_f = 1'b1;
        sb.push_back(8'h5A);
        @(negedge clk);
        wait_done_f("done_timeout_hold");
        viol = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (line_f !== 1'b1 || busy_f !== 1'b0 || done_f !== 1'b0) viol++;
        end
        chk("hold_no_refire", viol, 32'd0);
        istx_f = 1'b0;
        repeat (20) @(negedge clk);
        chk("hold_decoded_count", decoded, 32'd5);

        // Data changes mid-frame are ignored.
        data_f = 8'h3C;
        istx_f = 1'b1;
        sb.push_back(8'h3C);
        repeat (9) @(negedge clk);
        data_f = 8'hFF;
        repeat (10) @(negedge clk);
        data_f = 8'h00;
        wait_done_f("done_timeout_toggle");
        istx_f = 1'b0;
        repeat (20) @(negedge clk);
        chk("fast_decoded_count", decoded, 32'd6);
        chk("scoreboard_drained", sb.size(), 32'd0);

        // Reset in the middle of a full-rate frame.
        done_cnt = 0;
        data_s = 8'h55;
        istx_s = 1'b1;
        @(negedge clk);
        chk("rst_frame_started", {31'd0, line_s}, 32'd0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done_s) done_cnt++;
            @(negedge clk);
        end
        #1 reset_s = 1'b1;
        #1;
        chk("rst_line_immediate", {31'd0, line_s}, 32'd1);
        chk("rst_busy_immediate", {31'd0, busy_s}, 32'd0);
        istx_s = 1'b0;
        @(negedge clk);
        reset_s = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (done_s) done_cnt++;
            if (line_s !== 1'b1) done_cnt++;
            @(negedge clk);
        end
        chk("rst_no_done_idle_line", done_cnt, 32'd0);
        slow_frame(8'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
